// File: rtl/e_mdu.sv
// Multi-cycle MIPS multiply/divide unit for the E stage with HI/LO registers.
// Busy for a fixed latency per op class; HI/LO update on the final busy edge.
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_data1,
  input  logic [WIDTH-1:0] E_data2,
  input  logic [3:0]       E_mdu_op,
  input  logic             E_start,
  output logic             E_busy,
  output logic [WIDTH-1:0] E_hi,
  output logic [WIDTH-1:0] E_lo,
  output logic [WIDTH-1:0] E_mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi, lo;
  logic             start_ok, load, done, mt_hi, mt_lo;

  // result datapath, driven from latched operands only
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   dvs_s, dvs_u, q_s, r_s, q_u, r_u, res_hi, res_lo;
  logic               wb_en;

  assign start_ok = E_start && (E_mdu_op >= OP_MULT) && (E_mdu_op <= OP_DIVU);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        op_q <= E_mdu_op;
        a_q  <= E_data1;
        b_q  <= E_data2;
        cnt  <= (E_mdu_op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
      end
      if (done && wb_en) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (mt_hi) hi <= E_data1;
        if (mt_lo) lo <= E_data1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    E_busy = (state == RUN);
    load   = (state == IDLE) && start_ok;
    done   = (state == RUN) && (cnt == CNT_W'(1));
    mt_hi  = (state == IDLE) && (E_mdu_op == OP_MTHI);
    mt_lo  = (state == IDLE) && (E_mdu_op == OP_MTLO);
  end

  // Divide-by-zero and MIN/-1 both divide by one instead: the former is then
  // discarded, the latter yields exactly quotient=MIN, remainder=0.
  always_comb begin
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    dvs_u  = (b_q == '0) ? ONE : b_q;
    dvs_s  = ((b_q == '0) || (a_q == MIN_NEG && b_q == '1)) ? ONE : b_q;
    q_s    = $signed(a_q) / $signed(dvs_s);
    r_s    = $signed(a_q) % $signed(dvs_s);
    q_u    = a_q / dvs_u;
    r_u    = a_q % dvs_u;
    wb_en  = (op_q == OP_MULT) || (op_q == OP_MULTU) || (b_q != '0);
    res_hi = '0;
    res_lo = '0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      OP_MULTU: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      OP_DIV:   begin res_hi = r_s; res_lo = q_s; end
      OP_DIVU:  begin res_hi = r_u; res_lo = q_u; end
      default:  ;
    endcase
  end

  assign E_hi      = hi;
  assign E_lo      = lo;
  assign E_mdu_out = (E_mdu_op == OP_MFHI) ? hi :
                     (E_mdu_op == OP_MFLO) ? lo : '0;

endmodule
